// File: rtl/cpu_trace_buffer.sv
// Trace capture FIFO for retired-instruction snapshots: first-word-fall-through,
// sequence-tagged records, with sticky overflow and a saturating drop counter.
module cpu_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int SEQ_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic [31:0]                rs_value,
    input  logic [31:0]                rt_value,
    input  logic [31:0]                rd_value,
    input  logic [31:0]                pc,
    input  logic [31:0]                j_address,
    input  logic [31:0]                b_address,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_rs,
    output logic [31:0]                out_rt,
    output logic [31:0]                out_rd,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_j,
    output logic [31:0]                out_b,
    output logic [SEQ_W-1:0]           out_seq,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic [SEQ_W-1:0]           drop_count
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int REC_W = 6 * 32 + SEQ_W;

    // Handshake: a record moves to the consumer on any edge where out_valid and
    // out_ready are both high; out_valid never depends on out_ready, and the
    // head record is held unchanged until that edge.

    logic [REC_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [SEQ_W-1:0] seq;
    logic [REC_W-1:0] head;
    logic             push;
    logic             pop;
    logic             drop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign out_valid = !empty;

    assign pop  = out_valid && out_ready && !flush;
    assign push = sample_valid && !flush && (!full || pop);
    assign drop = sample_valid && !flush && full && !pop;

    // Empty buffer presents all-zero fields rather than a stale slot.
    assign head = empty ? '0 : mem[rd_ptr];
    assign {out_seq, out_b, out_j, out_pc, out_rd, out_rt, out_rs} = head;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {seq, b_address, j_address, pc, rd_value, rt_value, rs_value};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq        <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            // The tag counter sees every sample, so drops and flushes leave gaps.
            if (sample_valid)
                seq <= seq + 1'b1;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                overflow   <= 1'b0;
                drop_count <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (pop && !push)
                    count <= count - 1'b1;
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_count != '1)
                        drop_count <= drop_count + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: a reference queue model drives a scoreboard that is
// compared against the head record and status every cycle, plus directed checks.
module tb_cpu_trace_buffer;
    localparam int DEPTH = 16;
    localparam int SEQ_W = 16;
    localparam int RW    = 6 * 32 + SEQ_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sample_valid = 1'b0;
    logic [31:0]       rs_value = '0, rt_value = '0, rd_value = '0;
    logic [31:0]       pc = '0, j_address = '0, b_address = '0;
    logic              flush = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [31:0]       out_rs, out_rt, out_rd, out_pc, out_j, out_b;
    logic [SEQ_W-1:0]  out_seq;
    logic [4:0]        count;
    logic              full, empty, overflow;
    logic [SEQ_W-1:0]  drop_count;

    logic [RW-1:0]     got;
    logic [RW-1:0]     exp_q[$];
    logic [SEQ_W-1:0]  m_seq;
    logic              m_ov;
    logic [SEQ_W-1:0]  m_drops;
    int                checks = 0;
    int                fails  = 0;

    assign got = {out_seq, out_b, out_j, out_pc, out_rd, out_rt, out_rs};

    cpu_trace_buffer #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid),
        .rs_value(rs_value), .rt_value(rt_value), .rd_value(rd_value),
        .pc(pc), .j_address(j_address), .b_address(b_address),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_pc(out_pc), .out_j(out_j), .out_b(out_b), .out_seq(out_seq),
        .count(count), .full(full), .empty(empty),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic rand_data();
        rs_value  = $urandom; rt_value  = $urandom; rd_value  = $urandom;
        pc        = $urandom; j_address = $urandom; b_address = $urandom;
    endtask

    // One clock: apply inputs, check DUT against model before the edge, advance model.
    task automatic drive_cycle(input logic sv, input logic rdy, input logic fl);
        logic m_pop, m_push;
        sample_valid = sv; out_ready = rdy; flush = fl;
        @(negedge clk);
        checks++;
        if (count !== 5'(exp_q.size())) begin
            fails++; $display("FAIL count: got %0d expected %0d", count, exp_q.size());
        end
        checks++;
        if (out_valid !== (exp_q.size() != 0)) begin
            fails++; $display("FAIL out_valid: got %0b expected %0b", out_valid, exp_q.size() != 0);
        end
        checks++;
        if (exp_q.size() != 0) begin
            if (got !== exp_q[0]) begin
                fails++; $display("FAIL head_record: got %h expected %h", got, exp_q[0]);
            end
        end else if (got[191:0] !== '0) begin
            fails++; $display("FAIL empty_data_zero: got %h expected 0", got[191:0]);
        end
        checks++;
        if (overflow !== m_ov || drop_count !== m_drops) begin
            fails++; $display("FAIL overflow_drops: got %0b/%0d expected %0b/%0d",
                              overflow, drop_count, m_ov, m_drops);
        end
        m_pop  = (exp_q.size() != 0) && rdy && !fl;
        m_push = sv && !fl && (exp_q.size() < DEPTH || m_pop);
        if (fl) begin
            exp_q.delete(); m_ov = 1'b0; m_drops = '0;
        end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) exp_q.push_back({m_seq, b_address, j_address, pc, rd_value, rt_value, rs_value});
            if (sv && !m_push) begin
                m_ov = 1'b1;
                if (m_drops != '1) m_drops = m_drops + 1'b1;
            end
        end
        if (sv) m_seq = m_seq + 1'b1;
        @(posedge clk); #1;
        sample_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; sample_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        exp_q.delete(); m_seq = '0; m_ov = 1'b0; m_drops = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_valid !== 1'b0 || empty !== 1'b1 || full !== 1'b0 || count !== 5'd0) begin
            fails++; $display("FAIL reset_status: got v%0b e%0b f%0b c%0d expected v0 e1 f0 c0",
                              out_valid, empty, full, count);
        end
        checks++;
        if (overflow !== 1'b0 || drop_count !== '0 || got !== '0) begin
            fails++; $display("FAIL reset_outputs: got ov%0b d%0d rec %h expected all zero",
                              overflow, drop_count, got);
        end
    endtask

    task automatic test_single();
        do_reset();
        rand_data(); pc = 32'h0040_0000; rd_value = 32'h5;
        drive_cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0040_0000 || out_rd !== 32'h5 ||
            out_seq !== '0 || count !== 5'd1) begin
            fails++; $display("FAIL single_sample: got v%0b pc %h rd %h seq %0d c%0d expected v1 pc 00400000 rd 5 seq 0 c1",
                              out_valid, out_pc, out_rd, out_seq, count);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin rand_data(); drive_cycle(1'b1, 1'b0, 1'b0); end
        checks++;
        if (full !== 1'b1 || count !== 5'd16) begin
            fails++; $display("FAIL fill_full: got f%0b c%0d expected f1 c16", full, count);
        end
        rand_data(); drive_cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || drop_count !== 16'd1 || count !== 5'd16) begin
            fails++; $display("FAIL overflow_drop: got ov%0b d%0d c%0d expected ov1 d1 c16",
                              overflow, drop_count, count);
        end
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, 1'b0);
        rand_data(); drive_cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (out_seq !== 16'd17) begin
            fails++; $display("FAIL tag_after_drop: got %0d expected 17", out_seq);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin rand_data(); drive_cycle(1'b1, 1'b0, 1'b0); end
        rand_data(); drive_cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || out_seq !== 16'd1) begin
            fails++; $display("FAIL full_push_pop: got c%0d ov%0b head %0d expected c16 ov0 head 1",
                              count, overflow, out_seq);
        end
        for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin rand_data(); drive_cycle(1'b1, 1'b0, 1'b0); end
        for (int i = 0; i < 5; i++) begin
            rand_data(); drive_cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_seq !== 16'd0) begin
                fails++; $display("FAIL stall_hold: got v%0b seq %0d expected v1 seq 0", out_valid, out_seq);
            end
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (out_seq !== 16'd1) begin
            fails++; $display("FAIL stall_release: got %0d expected 1", out_seq);
        end
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin rand_data(); drive_cycle(1'b1, 1'b0, 1'b0); end
        for (int i = 0; i < 11; i++) drive_cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (count !== 5'd5 || overflow !== 1'b1) begin
            fails++; $display("FAIL pre_flush: got c%0d ov%0b expected c5 ov1", count, overflow);
        end
        rand_data(); drive_cycle(1'b1, 1'b1, 1'b1);
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || drop_count !== '0 || out_pc !== '0) begin
            fails++; $display("FAIL flush_clear: got c%0d e%0b ov%0b d%0d pc %h expected c0 e1 ov0 d0 pc 0",
                              count, empty, overflow, drop_count, out_pc);
        end
        rand_data(); drive_cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (out_seq !== 16'd18) begin
            fails++; $display("FAIL tag_after_flush: got %0d expected 18", out_seq);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin rand_data(); drive_cycle(1'b1, 1'b0, 1'b0); end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 ||
            overflow !== 1'b0 || drop_count !== '0 || got !== '0) begin
            fails++; $display("FAIL async_reset: got v%0b c%0d e%0b f%0b rec %h expected v0 c0 e1 f0 rec 0",
                              out_valid, count, empty, full, got);
        end
        do_reset();
        rand_data(); drive_cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (out_seq !== '0 || count !== 5'd1) begin
            fails++; $display("FAIL post_reset_tag: got seq %0d c%0d expected seq 0 c1", out_seq, count);
        end
        drive_cycle(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rand_data();
            drive_cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 60) == 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        m_seq = '0; m_ov = 1'b0; m_drops = '0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_stall();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of trace records held; power of two, 2..256.
REQ-002 Parameter SEQ_W, default 16, width of the record sequence tag and of the drop counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sample_valid  input  1  one retired instruction's snapshot is present on the sample buses this cycle.
REQ-006 rs_value, rt_value, rd_value  input  32 each  register values driven by the hardware side of the checker interface.
REQ-007 pc, j_address, b_address  input  32 each  PC, jump target and branch target from the same snapshot.
REQ-008 flush  input  1  synchronous clear of buffered records and error status.
REQ-009 out_valid  output  1  head record available.
REQ-010 out_ready  input  1  consumer (scoreboard/monitor side) accepts the head record.
REQ-011 out_rs, out_rt, out_rd, out_pc, out_j, out_b  output  32 each  head record fields.
REQ-012 out_seq  output  SEQ_W  sequence tag of the head record.
REQ-013 count  output  clog2(DEPTH)+1  records currently held.
REQ-014 full, empty  output  1 each  count==DEPTH, count==0.
REQ-015 overflow  output  1  sticky: at least one sample was dropped.
REQ-016 drop_count  output  SEQ_W  number of dropped samples, saturating.

Function
REQ-017 The block SHALL be a first-word-fall-through FIFO of DEPTH records, each record = six 32-bit fields plus an SEQ_W-bit tag.
REQ-018 Push SHALL occur when sample_valid=1, flush=0, and (full=0 or a pop occurs the same cycle).
REQ-019 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-020 A seq counter SHALL increment (mod 2^SEQ_W) on every cycle with sample_valid=1, including dropped and flushed samples; a pushed record is tagged with the pre-increment value.
REQ-021 Latency: a sample pushed into an empty FIFO at edge N SHALL appear with out_valid=1 immediately after edge N.
REQ-022 While out_valid=1 and out_ready=0, all out_* fields SHALL hold stable.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including when full or when count==1.
REQ-024 sample_valid=1 while full with no pop SHALL drop the sample, set overflow, and increment drop_count, saturating at all-ones.
REQ-025 Pop attempts when empty SHALL be impossible (out_valid=0); out_ready is ignored.
REQ-026 Read/write pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-027 flush=1 SHALL at the next edge set count=0, clear overflow and drop_count, discard any same-cycle sample and pop; seq counter SHALL still advance for a same-cycle sample.
REQ-028 out_* data fields SHALL read zero while empty=1.

Reset
REQ-029 reset=1 SHALL immediately clear pointers, count, seq counter, overflow, drop_count; out_valid=0, empty=1, full=0, all out_* fields zero.
REQ-030 Reset asserted mid-operation SHALL discard all held records; first push after deassertion is tagged seq 0.

Verification
REQ-031 Reset, then one sample pc=0x00400000, rd_value=0x5 -> next cycle out_valid=1, out_pc=0x00400000, out_rd=0x5, out_seq=0, count=1.
REQ-032 16 samples with out_ready=0 (DEPTH=16) -> full=1, count=16; 17th sample -> overflow=1, drop_count=1, count=16; then drain -> out_seq 0..15 in order, next pushed record tagged 17.
REQ-033 Full FIFO, sample_valid=1 and out_ready=1 same cycle -> count stays 16, overflow stays 0, new record appears at tail.
REQ-034 Hold out_ready=0 for 5 cycles with out_valid=1 -> out_* unchanged every cycle; assert out_ready -> next record presented.
REQ-035 flush=1 with count=5, overflow=1, concurrent sample -> next cycle count=0, empty=1, overflow=0, drop_count=0; next push tag = previous seq+1 (gap visible).
REQ-036 Assert reset asynchronously mid-cycle with count=3 -> out_valid falls without a clock edge; all status outputs at reset values.
